// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss fill controller (8 x 16-bit words per block), rev 1.0.
// Define CFSM_CRITICAL_WORD_FIRST_EN to issue and write the block starting at the missed word.
`default_nettype none

module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic [15:0] cache_array_data,
  output logic [2:0]  cache_memory_addr,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [15:0] memory_address,
  output logic        write_valid_bit
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [11:0] r_base;
  logic [3:0]  r_issue_cnt;
  logic [2:0]  r_recv_cnt;
  logic [2:0]  w_start;
  logic [2:0]  w_issue_off;
  logic [2:0]  w_issue_idx;
  logic [2:0]  w_recv_idx;
  logic        w_accept;
  logic        w_last_word;

`ifdef CFSM_CRITICAL_WORD_FIRST_EN
  logic [2:0] r_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= 3'd0;
    end else if (w_accept) begin
      r_start <= miss_address[3:1];
    end
  end

  assign w_start = r_start;
`else
  logic w_unused_offset;

  assign w_unused_offset = ^miss_address[3:0];
  assign w_start         = 3'd0;
`endif

  assign w_accept    = (r_state == IDLE) && miss_detected && wen;
  assign w_last_word = (r_state == FILL) && memory_data_valid && (r_recv_cnt == 3'd7);

  // Once all 8 addresses are out, keep presenting the last one.
  assign w_issue_off = (r_issue_cnt == 4'd8) ? 3'd7 : r_issue_cnt[2:0];
  assign w_issue_idx = w_issue_off + w_start;
  assign w_recv_idx  = r_recv_cnt + w_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = FILL;
      FILL:    if (w_last_word) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= 12'h000;
      r_issue_cnt <= 4'd0;
      r_recv_cnt  <= 3'd0;
    end else if (w_accept) begin
      r_base      <= miss_address[15:4];
      r_issue_cnt <= 4'd0;
      r_recv_cnt  <= 3'd0;
    end else if (r_state == FILL) begin
      if (w_last_word) begin
        r_issue_cnt <= 4'd0;
        r_recv_cnt  <= 3'd0;
      end else begin
        if (r_issue_cnt != 4'd8) begin
          r_issue_cnt <= r_issue_cnt + 4'd1;
        end
        if (memory_data_valid) begin
          r_recv_cnt <= r_recv_cnt + 3'd1;
        end
      end
    end
  end

  // The idle address is combinational from miss_address, so it is forced to zero while in reset.
  always_comb begin
    fsm_busy          = 1'b0;
    cache_array_data  = memory_data;
    cache_memory_addr = 3'd0;
    write_data_array  = 1'b0;
    write_tag_array   = 1'b0;
    write_valid_bit   = 1'b0;
    memory_address    = rst_n ? {miss_address[15:4], 4'h0} : 16'h0000;
    if (r_state == FILL) begin
      fsm_busy          = 1'b1;
      memory_address    = {r_base, w_issue_idx, 1'b0};
      cache_memory_addr = w_recv_idx;
      write_data_array  = memory_data_valid;
      write_tag_array   = w_last_word;
      write_valid_bit   = w_last_word;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench for cache_fill_fsm (addresses and data-array writes), rev 1.0.
`default_nettype none

module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic [15:0] cache_array_data;
  logic [2:0]  cache_memory_addr;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] memory_address;
  logic        write_valid_bit;

  int          n_tests;
  int          n_fail;
  logic [15:0] q_addr[$];
  logic [19:0] q_wr[$];   // {tag_expected, word_index, data}
  logic [15:0] last_addr;
  logic [2:0]  cur_start;
  int          cur_word;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wen               (wen),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .cache_array_data  (cache_array_data),
    .cache_memory_addr (cache_memory_addr),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .memory_address    (memory_address),
    .write_valid_bit   (write_valid_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] start_of(input logic [15:0] a);
`ifdef CFSM_CRITICAL_WORD_FIRST_EN
    return a[3:1];
`else
    return 3'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_addrs(input logic [15:0] a);
    logic [2:0] idx;
    cur_start = start_of(a);
    cur_word  = 0;
    for (int k = 0; k < 8; k++) begin
      idx = cur_start + 3'(k);
      q_addr.push_back({a[15:4], idx, 1'b0});
    end
  endtask

  // Presents a miss for one cycle (or leaves it asserted when hold=1) and checks entry.
  task automatic start_fill(input logic [15:0] a, input bit hold);
    miss_address  = a;
    miss_detected = 1'b1;
    wen           = 1'b1;
    push_addrs(a);
    @(negedge clk);
    chk("idle_addr", memory_address, {a[15:4], 4'h0});
    chk("busy_pre", fsm_busy, 0);
    tick();
    if (!hold) miss_detected = 1'b0;
    @(negedge clk);
    chk("busy_rise", fsm_busy, 1);
    chk("fill_cma0", cache_memory_addr, cur_start);
    tick();
  endtask

  task automatic send_word(input logic [15:0] d, input int gap);
    logic [2:0] idx;
    repeat (gap) tick();
    idx = cur_start + 3'(cur_word);
    q_wr.push_back({(cur_word == 7), idx, d});
    cur_word++;
    memory_data       = d;
    memory_data_valid = 1'b1;
    tick();
    memory_data_valid = 1'b0;
  endtask

  task automatic send_block(input int gap);
    for (int k = 1; k <= 8; k++) send_word(16'(k * 16'h1111), gap);
  endtask

  always @(negedge clk) begin
    logic [15:0] ea;
    logic [19:0] ew;
    if (rst_n) begin
      if (fsm_busy) begin
        if (q_addr.size() > 0) begin
          ea        = q_addr.pop_front();
          last_addr = ea;
        end else begin
          ea = last_addr;
        end
        chk("mem_addr", memory_address, ea);
      end else begin
        chk("idle_strobes", {write_data_array, write_tag_array, write_valid_bit}, 0);
      end
      if (write_data_array) begin
        if (q_wr.size() == 0) begin
          chk("unexpected_wr", write_data_array, 0);
        end else begin
          ew = q_wr.pop_front();
          chk("wr_idx", cache_memory_addr, ew[18:16]);
          chk("wr_data", cache_array_data, ew[15:0]);
          chk("wr_tag", write_tag_array, ew[19]);
          chk("wr_valid", write_valid_bit, ew[19]);
        end
      end else begin
        chk("tag_without_wr", {write_tag_array, write_valid_bit}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    last_addr         = 16'h0;
    cur_start         = 3'd0;
    cur_word          = 0;
    rst_n             = 1'b0;
    wen               = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'hBEEF;
    memory_data       = 16'hABCD;
    memory_data_valid = 1'b0;

    // Reset held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", fsm_busy, 0);
    chk("rst_strobes", {write_data_array, write_tag_array, write_valid_bit}, 0);
    chk("rst_cma", cache_memory_addr, 0);
    chk("rst_maddr", memory_address, 0);
    chk("rst_cad", cache_array_data, 16'hABCD);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", fsm_busy, 0);
    end
    tick();

    // Basic fill, one word every 4 cycles
    start_fill(16'h1234, 1'b0);
    send_block(3);
    @(negedge clk);
    chk("busy_fall", fsm_busy, 0);
    tick();

    // Gating: wen low, stray valid pulses in idle
    miss_address  = 16'h7770;
    miss_detected = 1'b1;
    wen           = 1'b0;
    for (int k = 0; k < 10; k++) begin
      memory_data_valid = k[0];
      @(negedge clk);
      chk("gate_busy", fsm_busy, 0);
      chk("gate_wda", write_data_array, 0);
      tick();
    end
    memory_data_valid = 1'b0;
    miss_detected     = 1'b0;

    // Reset mid-fill after 3 words
    start_fill(16'h5678, 1'b0);
    send_word(16'hA001, 1);
    send_word(16'hA002, 1);
    send_word(16'hA003, 1);
    #2;
    rst_n             = 1'b0;
    memory_data_valid = 1'b1;
    #1;
    chk("abort_busy", fsm_busy, 0);
    chk("abort_strobes", {write_data_array, write_tag_array, write_valid_bit}, 0);
    chk("abort_maddr", memory_address, 0);
    chk("abort_cma", cache_memory_addr, 0);
    memory_data_valid = 1'b0;
    q_addr.delete();
    q_wr.delete();
    tick();
    rst_n = 1'b1;
    tick();
    start_fill(16'h4000, 1'b0);
    send_block(0);
    @(negedge clk);
    chk("busy_fall2", fsm_busy, 0);
    tick();

    // Back-to-back with miss held high through completion
    start_fill(16'h2468, 1'b1);
    send_block(1);
    push_addrs(16'h2468);
    @(negedge clk);
    chk("b2b_gap", fsm_busy, 0);
    tick();
    @(negedge clk);
    chk("b2b_restart", fsm_busy, 1);
    chk("b2b_cma0", cache_memory_addr, cur_start);
    tick();
    miss_detected = 1'b0;
    send_block(2);
    @(negedge clk);
    chk("busy_fall3", fsm_busy, 0);
    tick();

    // Miss in the middle of a block (wraps under critical-word-first)
    start_fill(16'h123A, 1'b0);
    send_block(1);
    @(negedge clk);
    chk("busy_fall4", fsm_busy, 0);
    repeat (3) tick();

    chk("q_addr_empty", q_addr.size(), 0);
    chk("q_wr_empty", q_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
